// File: rtl/ngs_boot_core_nios2_fast_cpu_mul_combine_if.sv
// Request, multiplier-cell and response bundle for the fast-core multiply combiner.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface ngs_boot_core_nios2_fast_cpu_mul_combine_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_src1;
    logic [31:0]      req_src2;
    logic [TAG_W-1:0] req_tag;

    logic [31:0]      cell_src1;
    logic [31:0]      cell_src2;
    logic             cell_en;
    logic [31:0]      cell_p1;
    logic [31:0]      cell_p2;
    logic [31:0]      cell_p3;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;

    modport slave (
        input  req_valid, req_src1, req_src2, req_tag,
        input  cell_p1, cell_p2, cell_p3,
        input  rsp_ready,
        output req_ready,
        output cell_src1, cell_src2, cell_en,
        output rsp_valid, rsp_result, rsp_tag
    );

    modport master (
        output req_valid, req_src1, req_src2, req_tag,
        output cell_p1, cell_p2, cell_p3,
        output rsp_ready,
        input  req_ready,
        input  cell_src1, cell_src2, cell_en,
        input  rsp_valid, rsp_result, rsp_tag
    );
endinterface

// File: rtl/ngs_boot_core_nios2_fast_cpu_mul_combine.sv
// Sequences one 32x32 request through the three-product 16x16 cell and
// assembles the low product word: lo + ((lo*hi + hi*lo) << 16), all mod 2^32.
module ngs_boot_core_nios2_fast_cpu_mul_combine #(
    parameter int TAG_W = 4
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic                                       flush,
    ngs_boot_core_nios2_fast_cpu_mul_combine_if.slave  bus,
    output logic [2:0]                                 dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        SUM     = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t           state;
    logic [31:0]      src1_q;
    logic [31:0]      src2_q;
    logic             en_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      lo_q;
    logic [15:0]      mid_q;
    logic [31:0]      result_q;
    logic             valid_q;

    // Upper halves of the cross products only affect bits above 31.
    logic unused_hi;
    assign unused_hi = ^{bus.cell_p2[31:16], bus.cell_p3[31:16]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            src1_q   <= '0;
            src2_q   <= '0;
            en_q     <= 1'b0;
            tag_q    <= '0;
            lo_q     <= '0;
            mid_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && !flush) begin
                        src1_q <= bus.req_src1;
                        src2_q <= bus.req_src2;
                        tag_q  <= bus.req_tag;
                        en_q   <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= flush ? IDLE : CAPTURE;
                end
                CAPTURE: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        lo_q  <= bus.cell_p1;
                        mid_q <= bus.cell_p2[15:0] + bus.cell_p3[15:0];
                        state <= SUM;
                    end
                end
                SUM: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        result_q <= lo_q + {mid_q, 16'h0000};
                        valid_q  <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    // flush wins over a simultaneous consumer accept.
                    if (flush || bus.rsp_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.cell_src1  = src1_q;
    assign bus.cell_src2  = src2_q;
    assign bus.cell_en    = en_q;
    assign bus.rsp_valid  = valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_tag    = tag_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_ngs_boot_core_nios2_fast_cpu_mul_combine.sv
// Directed plus randomized bench: a behavioural 16x16 cell model feeds the DUT,
// and every response is compared with the full 64-bit product truncated to 32 bits.
module tb_ngs_boot_core_nios2_fast_cpu_mul_combine;

    localparam int TAG_W = 4;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0]      exp_q[$];
    logic [TAG_W-1:0] tag_q[$];

    ngs_boot_core_nios2_fast_cpu_mul_combine_if #(.TAG_W(TAG_W)) bus ();

    ngs_boot_core_nios2_fast_cpu_mul_combine #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // multiplier cell: registers the three partial products on its enabled edge
    always @(posedge clk) begin
        if (bus.cell_en) begin
            bus.cell_p1 <= 32'(bus.cell_src1[15:0]) * 32'(bus.cell_src2[15:0]);
            bus.cell_p2 <= 32'(bus.cell_src1[15:0]) * 32'(bus.cell_src2[31:16]);
            bus.cell_p3 <= 32'(bus.cell_src1[31:16]) * 32'(bus.cell_src2[15:0]);
        end
    end

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = 64'(a) * 64'(b);
        return full[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // driver: waits (bounded) for req_ready, presents one request, returns after the accept edge
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_src1  = a;
        bus.req_src2  = b;
        bus.req_tag   = t;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        exp_q.push_back(ref_mul(a, b));
        tag_q.push_back(t);
        chk("issue_cell_en", 32'(bus.cell_en), 32'd1);
        chk("issue_src1", bus.cell_src1, a);
        chk("issue_src2", bus.cell_src2, b);
        chk("issue_req_ready", 32'(bus.req_ready), 32'd0);
    endtask

    // full operation with bp cycles of response backpressure
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                          input int bp);
        logic [31:0]      e_res;
        logic [TAG_W-1:0] e_tag;
        accept(a, b, t);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(posedge clk);
            #1;
            chk("lat_rsp_valid", 32'(bus.rsp_valid), 32'(cyc == 3));
            chk("lat_cell_en", 32'(bus.cell_en), 32'd0);
            chk("lat_src1_hold", bus.cell_src1, a);
        end
        e_res = exp_q.pop_front();
        e_tag = tag_q.pop_front();
        chk("rsp_result", bus.rsp_result, e_res);
        chk("rsp_tag", 32'(bus.rsp_tag), 32'(e_tag));
        if (bp > 0) begin
            bus.req_valid = 1'b1;
            bus.req_src1  = ~a;
            bus.req_src2  = ~b;
        end
        for (int k = 0; k < bp; k++) begin
            @(posedge clk);
            #1;
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_result", bus.rsp_result, e_res);
            chk("bp_tag", 32'(bus.rsp_tag), 32'(e_tag));
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_cell_en", 32'(bus.cell_en), 32'd0);
            chk("bp_no_accept", bus.cell_src1, a);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("hs_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    // flush raised during stage st (1=ISSUE, 2=CAPTURE, 3=SUM, 4=RESP)
    task automatic flush_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                            input int st);
        accept(a, b, t);
        for (int i = 1; i < st; i++) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        bus.rsp_ready = (st == 4);
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.rsp_ready = 1'b0;
        void'(exp_q.pop_back());
        void'(tag_q.pop_back());
        chk("flush_req_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("flush_no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("flush_cell_en", 32'(bus.cell_en), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] prev_src1;

        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_src1  = '0;
        bus.req_src2  = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_cell_en", 32'(bus.cell_en), 32'd0);
        chk("rst_cell_src1", bus.cell_src1, 32'd0);
        chk("rst_cell_src2", bus.cell_src2, 32'd0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        chk("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // directed plan
        run_op(32'h0000_0003, 32'h0000_0005, 4'h1, 0);
        run_op(32'h0001_2345, 32'h0001_0001, 4'h2, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3, 0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 4'hA, 3);
        flush_op(32'h0000_0010, 32'h0000_0010, 4'h5, 2);
        run_op(32'h0000_0007, 32'h0000_0009, 4'h6, 0);
        flush_op(32'h0000_0011, 32'h0000_0013, 4'h7, 1);
        flush_op(32'h0000_0021, 32'h0000_0023, 4'h8, 3);
        flush_op(32'h0000_0031, 32'h0000_0033, 4'h9, 4);

        // flush in IDLE discards a same-cycle request
        prev_src1 = bus.cell_src1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_src1  = 32'hDEAD_BEEF;
        bus.req_src2  = 32'h0000_0002;
        flush         = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        flush         = 1'b0;
        chk("idle_flush_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_flush_cell_en", 32'(bus.cell_en), 32'd0);
        chk("idle_flush_src1", bus.cell_src1, prev_src1);

        // reset pulse during SUM
        accept(32'h0000_0055, 32'h0000_0101, 4'hC);
        void'(exp_q.pop_back());
        void'(tag_q.pop_back());
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_src1", bus.cell_src1, 32'd0);
        chk("mid_rst_src2", bus.cell_src2, 32'd0);
        chk("mid_rst_cell_en", 32'(bus.cell_en), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_result", bus.rsp_result, 32'd0);
        chk("mid_rst_tag", 32'(bus.rsp_tag), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_src1  = 32'h0000_0abc;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ignore_req", bus.cell_src1, 32'd0);
        chk("rst_ignore_en", 32'(bus.cell_en), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        run_op(32'h0000_0002, 32'h0000_0008, 4'hD, 0);

        // randomized operations with random backpressure
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'hFFFF_FFFF;
            if ($urandom_range(0, 5) == 0) rb = {16'h0000, rb[15:0]};
            run_op(ra, rb, TAG_W'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
